// File: rtl/isp_2dnr_cfg_ctrl.sv
// 2DNR configuration controller: shadow/active coefficient banks, swapped on a
// frame boundary after a monotonicity check of the range-curve abscissae.
module isp_2dnr_cfg_ctrl #(
  parameter int BITS        = 8,
  parameter int WEIGHT_BITS = 5
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      in_vsync,
  // Handshake: a write transfers on a pclk edge where wr_valid & wr_ready;
  // wr_ready is registered and never depends on wr_valid.
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [6:0]                wr_addr,
  input  logic [BITS-1:0]           wr_data,
  output logic [49*WEIGHT_BITS-1:0] space_kernel,
  output logic [9*BITS-1:0]         color_curve_x,
  output logic [9*WEIGHT_BITS-1:0]  color_curve_y,
  output logic                      bypass,
  output logic                      cfg_busy,
  output logic                      commit_done,
  output logic [1:0]                cfg_err,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_CHECK = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  state_t                 state;
  logic                   vsync_d;
  logic [2:0]             chk_idx;
  logic [WEIGHT_BITS-1:0] sh_w [49];
  logic [WEIGHT_BITS-1:0] act_w [49];
  logic [BITS-1:0]        sh_x [9];
  logic [BITS-1:0]        act_x [9];
  logic [WEIGHT_BITS-1:0] sh_y [9];
  logic [WEIGHT_BITS-1:0] act_y [9];
  logic                   sh_byp;

  logic       wr_fire, vs_rise;
  logic       is_w, is_x, is_y, is_ctrl, is_bad;
  logic       chk_fail, err_clr;
  logic [3:0] x_idx, y_idx, cmp_lo, cmp_hi;
  logic [1:0] err_next;

  always_comb begin
    wr_fire  = wr_valid & wr_ready;
    vs_rise  = in_vsync & ~vsync_d;
    is_w     = (wr_addr < 7'd49);
    is_x     = (wr_addr >= 7'd49) && (wr_addr < 7'd58);
    is_y     = (wr_addr >= 7'd58) && (wr_addr < 7'd67);
    is_ctrl  = (wr_addr == 7'd67);
    is_bad   = (wr_addr > 7'd67);
    x_idx    = 4'(wr_addr - 7'd49);
    y_idx    = 4'(wr_addr - 7'd58);
    cmp_lo   = {1'b0, chk_idx};
    cmp_hi   = cmp_lo + 4'd1;
    chk_fail = (state == S_CHECK) && (sh_x[cmp_hi] < sh_x[cmp_lo]);
    err_clr  = wr_fire & is_ctrl & wr_data[2];
    err_next = cfg_err;
    if (chk_fail)          err_next[0] = 1'b1;
    if (state == S_LOAD)   err_next[0] = 1'b0;
    if (wr_fire && is_bad) err_next[1] = 1'b1;
    // A clear request always beats a same-cycle set.
    if (err_clr)           err_next    = 2'b00;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= S_IDLE;
      vsync_d     <= 1'b0;
      chk_idx     <= 3'd0;
      wr_ready    <= 1'b1;
      cfg_busy    <= 1'b0;
      commit_done <= 1'b0;
      cfg_err     <= 2'b00;
      sh_byp      <= 1'b0;
      bypass      <= 1'b0;
      for (int k = 0; k < 49; k++) begin
        sh_w[k]  <= WEIGHT_BITS'(1);
        act_w[k] <= WEIGHT_BITS'(1);
      end
      for (int i = 0; i < 9; i++) begin
        sh_x[i]  <= BITS'(16 * (i + 1));
        act_x[i] <= BITS'(16 * (i + 1));
        sh_y[i]  <= WEIGHT_BITS'(8 - i);
        act_y[i] <= WEIGHT_BITS'(8 - i);
      end
    end else begin
      vsync_d     <= in_vsync;
      commit_done <= 1'b0;
      cfg_err     <= err_next;
      if (wr_fire) begin
        if (is_w)    sh_w[wr_addr[5:0]] <= wr_data[WEIGHT_BITS-1:0];
        if (is_x)    sh_x[x_idx]        <= wr_data;
        if (is_y)    sh_y[y_idx]        <= wr_data[WEIGHT_BITS-1:0];
        if (is_ctrl) sh_byp             <= wr_data[1];
      end
      case (state)
        S_IDLE: begin
          if (wr_fire && is_ctrl && wr_data[0]) begin
            state    <= S_PEND;
            cfg_busy <= 1'b1;
          end
        end
        S_PEND: begin
          if (vs_rise) begin
            state    <= S_CHECK;
            chk_idx  <= 3'd0;
            wr_ready <= 1'b0;
          end
        end
        S_CHECK: begin
          if (chk_fail) begin
            state    <= S_IDLE;
            cfg_busy <= 1'b0;
            wr_ready <= 1'b1;
          end else if (chk_idx == 3'd7) begin
            state <= S_LOAD;
          end else begin
            chk_idx <= chk_idx + 3'd1;
          end
        end
        S_LOAD: begin
          act_w       <= sh_w;
          act_x       <= sh_x;
          act_y       <= sh_y;
          bypass      <= sh_byp;
          commit_done <= 1'b1;
          state       <= S_IDLE;
          cfg_busy    <= 1'b0;
          wr_ready    <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    space_kernel  = '0;
    color_curve_x = '0;
    color_curve_y = '0;
    for (int k = 0; k < 49; k++) space_kernel[WEIGHT_BITS*k +: WEIGHT_BITS] = act_w[k];
    for (int i = 0; i < 9; i++) begin
      color_curve_x[BITS*i +: BITS]               = act_x[i];
      color_curve_y[WEIGHT_BITS*i +: WEIGHT_BITS] = act_y[i];
    end
  end

  assign dbg_state = state;

endmodule
